// File: rtl/io_out_uart_tx_if.sv
// Output channel between the core and the UART transmitter: data word, one-cycle request, busy.
// Latency: none, the interface only carries wires.
// Backpressure: out_busy from the slave tells the master to hold off issuing out_req.
//
// Signals:
//   out_data  [31:0]  word from the core, valid while out_req=1
//   out_req           one-cycle push request
//   out_busy          1 = consumer cannot take another word
interface io_out_uart_tx_if;
  logic [31:0] out_data;
  logic        out_req;
  logic        out_busy;

  modport master (
    output out_data,
    output out_req,
    input  out_busy
  );

  modport slave (
    input  out_data,
    input  out_req,
    output out_busy
  );
endinterface

// File: rtl/io_out_uart_tx.sv
// Byte FIFO + 8N1 UART transmitter (LSB first) consuming the core's output channel.
// Latency: word accepted at edge t from an idle, empty state -> pop at t+1 -> start bit on txd at t+2.
// Backpressure: registered out_busy while free FIFO space < OUT_BYTES; requests made while busy are dropped and set overflow.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ou         slave side of io_out_uart_tx_if (out_data, out_req in; out_busy out)
//   txd        UART serial line, idle high
//   tx_active  high while a frame (start..stop) is on txd
//   overflow   sticky: a request arrived while out_busy was high
module io_out_uart_tx #(
  parameter int CLK_PER_BAUD = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int OUT_BYTES    = 1
) (
  input  logic                clk,
  input  logic                rst,
  io_out_uart_tx_if.slave     ou,
  output logic                txd,
  output logic                tx_active,
  output logic                overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BCNT_W = $clog2(CLK_PER_BAUD);

  localparam logic [PTR_W-1:0]  PTR_STEP  = PTR_W'(OUT_BYTES);
  localparam logic [CNT_W-1:0]  CNT_STEP  = CNT_W'(OUT_BYTES);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLK_PER_BAUD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  state_t           state_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             tx_active_q;

  logic             push;
  logic             pop;

  // Only the low OUT_BYTES bytes of the word are stored.
  logic             unused_data;
  assign unused_data = ^ou.out_data;

  always_comb begin
    push       = ou.out_req && !busy_q;
    pop        = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d   = push ? (wr_ptr_q + PTR_STEP) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q + (push ? CNT_STEP : '0) - (pop ? CNT_W'(1) : '0);
    // Busy is computed from the post-update count and registered, so out_busy
    // has no combinational dependency on out_req.
    busy_d     = (CNT_DEPTH - count_d) < CNT_STEP;
    overflow_d = overflow_q | (ou.out_req & busy_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int b = 0; b < OUT_BYTES; b++) begin
        fifo_mem[wr_ptr_q + PTR_W'(b)] <= ou.out_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM. txd/tx_active are registered from the current state, so the line
  // trails the state by one cycle; every bit still lasts CLK_PER_BAUD cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      tx_active_q <= 1'b0;
    end else begin
      txd_q       <= (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[0] : 1'b1;
      tx_active_q <= (state_q != IDLE);

      unique case (state_q)
        IDLE: begin
          bcnt_q <= '0;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            state_q <= START;
          end
        end
        START: begin
          if (bcnt_q == BCNT_LAST) begin
            bcnt_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        DATA: begin
          if (bcnt_q == BCNT_LAST) begin
            bcnt_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        STOP: begin
          if (bcnt_q == BCNT_LAST) begin
            bcnt_q  <= '0;
            state_q <= IDLE;
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        default: begin
          bcnt_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ou.out_busy = busy_q;
  assign txd         = txd_q;
  assign tx_active   = tx_active_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_io_out_uart_tx.sv
// Bench for io_out_uart_tx: one instance taking 1 byte per request, one taking 4.
// Latency: n/a.
// Backpressure: the drivers honour out_busy except where a dropped request is provoked on purpose.
module tb_io_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic txd1, tx_active1, overflow1;
  logic txd4, tx_active4, overflow4;

  io_out_uart_tx_if if1 ();
  io_out_uart_tx_if if4 ();

  io_out_uart_tx #(.CLK_PER_BAUD(CPB), .FIFO_DEPTH(DEPTH), .OUT_BYTES(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .ou        (if1),
    .txd       (txd1),
    .tx_active (tx_active1),
    .overflow  (overflow1)
  );

  io_out_uart_tx #(.CLK_PER_BAUD(CPB), .FIFO_DEPTH(DEPTH), .OUT_BYTES(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .ou        (if4),
    .txd       (txd4),
    .tx_active (tx_active4),
    .overflow  (overflow4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q4[$];
  int starts[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic txd_of(input int d);
    return (d == 0) ? txd1 : txd4;
  endfunction

  function automatic logic act_of(input int d);
    return (d == 0) ? tx_active1 : tx_active4;
  endfunction

  // UART receiver: samples every negedge across a 40-cycle frame, checks
  // framing and bit widths, then compares the byte with the scoreboard.
  task automatic mon(input int d);
    logic prev;
    logic v;
    logic ok;
    logic abort;
    logic [7:0] b;
    logic [7:0] e;
    int pos;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      v = txd_of(d);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !v) begin
        starts[d]++;
        ok = 1'b1;
        abort = 1'b0;
        b = '0;
        for (int i = 0; i < 10*CPB; i++) begin
          if (i > 0) begin
            @(negedge clk);
            v = txd_of(d);
          end
          if (rst) begin
            abort = 1'b1;
            break;
          end
          pos = i / CPB;
          if (!act_of(d)) ok = 1'b0;
          if (pos == 0) begin
            if (v !== 1'b0) ok = 1'b0;
          end else if (pos == 9) begin
            if (v !== 1'b1) ok = 1'b0;
          end else if (i % CPB == 0) begin
            b[pos-1] = v;
          end else if (v !== b[pos-1]) begin
            ok = 1'b0;
          end
        end
        if (!abort) begin
          check_eq((d == 0) ? "frame_fmt1" : "frame_fmt4", {31'd0, ok}, 32'd1);
          if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
            check_eq((d == 0) ? "sb_extra1" : "sb_extra4", {24'd0, b}, 32'h100);
          end else begin
            e = (d == 0) ? q1.pop_front() : q4.pop_front();
            check_eq((d == 0) ? "byte1" : "byte4", {24'd0, b}, {24'd0, e});
          end
        end
        prev = 1'b1;
      end else begin
        prev = v;
      end
    end
  endtask

  task automatic send1(input logic [7:0] b);
    int n;
    n = 0;
    while (if1.out_busy && n < 500) begin
      if1.out_req = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check_eq("send1_wait", {31'd0, (n < 500)}, 32'd1);
    if1.out_req  = 1'b1;
    if1.out_data = {24'hABCDEF, b};
    q1.push_back(b);
    @(posedge clk); #1;
    if1.out_req = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    int n;
    n = 0;
    while (if4.out_busy && n < 500) begin
      if4.out_req = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check_eq("send4_wait", {31'd0, (n < 500)}, 32'd1);
    if4.out_req  = 1'b1;
    if4.out_data = w;
    for (int i = 0; i < 4; i++) q4.push_back(w[8*i +: 8]);
    @(posedge clk); #1;
    if4.out_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0 || tx_active1 || tx_active4) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, {31'd0, (n < 3000)}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n_act;
    starts[0] = 0;
    starts[1] = 0;
    rst = 1'b1;
    if1.out_req = 1'b0; if1.out_data = '0;
    if4.out_req = 1'b0; if4.out_data = '0;
    fork
      mon(0);
      mon(1);
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd1",  {31'd0, txd1},        32'd1);
    check_eq("rst_act1",  {31'd0, tx_active1},  32'd0);
    check_eq("rst_busy1", {31'd0, if1.out_busy}, 32'd0);
    check_eq("rst_ovf1",  {31'd0, overflow1},   32'd0);
    check_eq("rst_txd4",  {31'd0, txd4},        32'd1);
    check_eq("rst_act4",  {31'd0, tx_active4},  32'd0);
    check_eq("rst_busy4", {31'd0, if4.out_busy}, 32'd0);
    check_eq("rst_ovf4",  {31'd0, overflow4},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte 0x41: start bit two edges after acceptance, 40 active cycles.
    send1(8'h41);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (txd1 && k < 20);
    check_eq("t1_latency", k, 2);
    n_act = 0;
    while (tx_active1 && n_act < 100) begin
      n_act++;
      @(posedge clk); #1;
    end
    check_eq("t1_active_len", n_act, 10*CPB);
    check_eq("t1_ovf", {31'd0, overflow1}, 32'd0);
    drain("t1_drain");

    // Nine back-to-back requests fill the FIFO (one byte already popped).
    for (int i = 0; i < 9; i++) begin
      send1(8'h10 + 8'(i*7));
      if (i == 7) check_eq("t2_busy_after8", {31'd0, if1.out_busy}, 32'd0);
    end
    check_eq("t2_busy_after9", {31'd0, if1.out_busy}, 32'd1);
    check_eq("t3_ovf_before", {31'd0, overflow1}, 32'd0);
    // Request against busy: dropped, sticky overflow, no extra frame.
    if1.out_req  = 1'b1;
    if1.out_data = 32'h0000_00FF;
    @(posedge clk); #1;
    if1.out_req = 1'b0;
    check_eq("t3_ovf_set", {31'd0, overflow1}, 32'd1);
    drain("t2_drain");
    check_eq("t3_ovf_sticky", {31'd0, overflow1}, 32'd1);

    // Four-byte words: second push coincides with the first pop at count 4.
    send4(32'h4443_4241);
    send4(32'h4847_4645);
    check_eq("t5_busy_cnt7", {31'd0, if4.out_busy}, 32'd1);
    k = 0;
    while (if4.out_busy && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("t4_busy_fall_seen", {31'd0, (k < 1000)}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_pops_at_unbusy", starts[1], 4);
    send4(32'h5453_5251);
    send4(32'h6463_6261);
    drain("t4_drain");
    check_eq("t4_ovf", {31'd0, overflow4}, 32'd0);

    // Reset in the middle of data bit 3.
    send1(8'hA5);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (txd1 && k < 20);
    check_eq("t6_start_seen", {31'd0, (k < 20)}, 32'd1);
    repeat (4*CPB + 1) @(posedge clk);
    #1;
    q1.delete();
    rst = 1'b1;
    #1;
    check_eq("t6_txd",  {31'd0, txd1},         32'd1);
    check_eq("t6_act",  {31'd0, tx_active1},   32'd0);
    check_eq("t6_busy", {31'd0, if1.out_busy}, 32'd0);
    check_eq("t6_ovf",  {31'd0, overflow1},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    k = starts[0];
    send1(8'h55);
    drain("t6_drain");
    check_eq("t6_one_frame", starts[0] - k, 1);

    check_eq("sb_left1", q1.size(), 0);
    check_eq("sb_left4", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
